// File: rtl/if_id_pipe.sv
// IF/ID pipeline register: 2-entry skid buffer between fetch and decode,
// with registered immediate-format predecode of the head instruction.
module if_id_pipe #(
  parameter int unsigned PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc,
  output logic [24:0]     raw_src,
  output logic [2:0]      imm_src,
  output logic            illegal
);

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OP_W    = 7;

  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_S    = 3'b001;
  localparam logic [2:0] IMM_B    = 3'b010;
  localparam logic [2:0] IMM_J    = 3'b011;
  localparam logic [2:0] IMM_U    = 3'b100;
  localparam logic [2:0] IMM_NONE = 3'b111;

  // Immediate format selected by the opcode field.
  function automatic logic [2:0] imm_fmt(input logic [OP_W-1:0] op);
    logic [2:0] f;
    f = IMM_NONE;
    case (op)
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: f = IMM_I;
      7'b0100011:                                     f = IMM_S;
      7'b1100011:                                     f = IMM_B;
      7'b1101111:                                     f = IMM_J;
      7'b0110111, 7'b0010111:                         f = IMM_U;
      default:                                        f = IMM_NONE;
    endcase
    return f;
  endfunction

  // R-type carries no immediate but is still a recognized opcode.
  function automatic logic op_unknown(input logic [OP_W-1:0] op);
    return (imm_fmt(op) == IMM_NONE) && (op != 7'b0110011);
  endfunction

  logic               main_valid, main_valid_n;
  logic [INSTR_W-1:0] main_instr, main_instr_n;
  logic [PC_W-1:0]    main_pc, main_pc_n;
  logic               skid_valid, skid_valid_n;
  logic [INSTR_W-1:0] skid_instr, skid_instr_n;
  logic [PC_W-1:0]    skid_pc, skid_pc_n;
  logic               in_ready_q;
  logic [2:0]         imm_src_q;
  logic               illegal_q;
  logic               accept;
  logic               pop;

  assign accept = in_valid & in_ready_q & ~flush;
  assign pop    = main_valid & out_ready;

  // Next-state for the head and skid entries; flush wins over everything.
  always_comb begin
    main_valid_n = main_valid;
    main_instr_n = main_instr;
    main_pc_n    = main_pc;
    skid_valid_n = skid_valid;
    skid_instr_n = skid_instr;
    skid_pc_n    = skid_pc;
    if (flush) begin
      main_valid_n = 1'b0;
      skid_valid_n = 1'b0;
    end else if (pop && skid_valid) begin
      main_valid_n = 1'b1;
      main_instr_n = skid_instr;
      main_pc_n    = skid_pc;
      skid_valid_n = 1'b0;
    end else if (accept && (!main_valid || pop)) begin
      main_valid_n = 1'b1;
      main_instr_n = in_instr;
      main_pc_n    = in_pc;
    end else if (accept) begin
      skid_valid_n = 1'b1;
      skid_instr_n = in_instr;
      skid_pc_n    = in_pc;
    end else if (pop) begin
      main_valid_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_instr <= '0;
      main_pc    <= '0;
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
      in_ready_q <= 1'b1;
      imm_src_q  <= IMM_NONE;
      illegal_q  <= 1'b0;
    end else begin
      main_valid <= main_valid_n;
      main_instr <= main_instr_n;
      main_pc    <= main_pc_n;
      skid_valid <= skid_valid_n;
      skid_instr <= skid_instr_n;
      skid_pc    <= skid_pc_n;
      in_ready_q <= ~skid_valid_n;
      // Predecode tracks the head data so it is ready with the head itself.
      imm_src_q  <= imm_fmt(main_instr_n[OP_W-1:0]);
      illegal_q  <= main_valid_n & op_unknown(main_instr_n[OP_W-1:0]);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid;
  assign out_instr = main_instr;
  assign out_pc    = main_pc;
  assign raw_src   = main_instr[31:7];
  assign imm_src   = imm_src_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_if_id_pipe.sv
// Directed table-driven bench for if_id_pipe: streaming, backpressure,
// flush, predecode and asynchronous reset behaviour.
module tb_if_id_pipe;

  localparam int unsigned PC_W = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [PC_W-1:0] out_pc;
  logic [24:0]     raw_src;
  logic [2:0]      imm_src;
  logic            illegal;

  if_id_pipe #(.PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .raw_src(raw_src), .imm_src(imm_src), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ordy;
    logic        fl;
    logic        e_ov;
    logic        e_ir;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [2:0]  e_imm;
    logic        e_ill;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic iv, input logic [31:0] instr, input logic [31:0] pc,
                     input logic ordy, input logic fl, input logic e_ov, input logic e_ir,
                     input logic [31:0] e_instr, input logic [31:0] e_pc,
                     input logic [2:0] e_imm, input logic e_ill);
    vec_t v;
    v.iv = iv; v.instr = instr; v.pc = pc; v.ordy = ordy; v.fl = fl;
    v.e_ov = e_ov; v.e_ir = e_ir; v.e_instr = e_instr; v.e_pc = e_pc;
    v.e_imm = e_imm; v.e_ill = e_ill;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic iv, input logic [31:0] instr, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    in_valid = iv; in_instr = instr; in_pc = pc; out_ready = ordy; flush = fl;
  endtask

  initial begin
    logic [31:0] tmp;
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    //  iv  instr          pc       ordy fl  ov   ir   e_instr        e_pc     imm     ill
    // reset then stream with decode always ready
    add(1, 32'h00500093, 32'h100, 1, 0, 1, 1, 32'h00500093, 32'h100, 3'b000, 0);
    add(1, 32'h00112023, 32'h104, 1, 0, 1, 1, 32'h00112023, 32'h104, 3'b001, 0);
    add(1, 32'hFE000EE3, 32'h108, 1, 0, 1, 1, 32'hFE000EE3, 32'h108, 3'b010, 0);
    add(1, 32'h008000EF, 32'h10C, 1, 0, 1, 1, 32'h008000EF, 32'h10C, 3'b011, 0);
    add(1, 32'h123452B7, 32'h110, 1, 0, 1, 1, 32'h123452B7, 32'h110, 3'b100, 0);
    add(0, 32'h0,        32'h0,   1, 0, 0, 1, 32'h0,        32'h0,   3'b100, 0);
    // backpressure: three offers, two accepted, then drain in order
    add(1, 32'h00A00113, 32'h200, 0, 0, 1, 1, 32'h00A00113, 32'h200, 3'b000, 0);
    add(1, 32'h00202223, 32'h204, 0, 0, 1, 0, 32'h00A00113, 32'h200, 3'b000, 0);
    add(1, 32'h00300193, 32'h208, 0, 0, 1, 0, 32'h00A00113, 32'h200, 3'b000, 0);
    add(1, 32'h00300193, 32'h208, 1, 0, 1, 1, 32'h00202223, 32'h204, 3'b001, 0);
    // accept+pop with skid empty: new word replaces head, no bubble
    add(1, 32'h00300193, 32'h208, 1, 0, 1, 1, 32'h00300193, 32'h208, 3'b000, 0);
    add(0, 32'h0,        32'h0,   0, 0, 1, 1, 32'h00300193, 32'h208, 3'b000, 0);
    // R-type and illegal opcode predecode, illegal held while stalled
    add(1, 32'h002081B3, 32'h20C, 1, 0, 1, 1, 32'h002081B3, 32'h20C, 3'b111, 0);
    add(1, 32'h0000007F, 32'h210, 1, 0, 1, 1, 32'h0000007F, 32'h210, 3'b111, 1);
    add(0, 32'h0,        32'h0,   0, 0, 1, 1, 32'h0000007F, 32'h210, 3'b111, 1);
    add(0, 32'h0,        32'h0,   1, 0, 0, 1, 32'h0,        32'h0,   3'b111, 0);
    // flush while full, offering nop that must never appear
    add(1, 32'h00100093, 32'h300, 0, 0, 1, 1, 32'h00100093, 32'h300, 3'b000, 0);
    add(1, 32'h00200113, 32'h304, 0, 0, 1, 0, 32'h00100093, 32'h300, 3'b000, 0);
    add(1, 32'h00000013, 32'h308, 0, 1, 0, 1, 32'h0,        32'h0,   3'b000, 0);
    add(0, 32'h0,        32'h0,   1, 0, 0, 1, 32'h0,        32'h0,   3'b000, 0);
    // flush with room available still drops the incoming word
    add(1, 32'h00000013, 32'h400, 1, 1, 0, 1, 32'h0,        32'h0,   3'b000, 0);
    add(0, 32'h0,        32'h0,   1, 0, 0, 1, 32'h0,        32'h0,   3'b000, 0);
    // flush coinciding with a pop clears the remaining skid entry
    add(1, 32'h00500093, 32'h500, 0, 0, 1, 1, 32'h00500093, 32'h500, 3'b000, 0);
    add(1, 32'h00112023, 32'h504, 0, 0, 1, 0, 32'h00500093, 32'h500, 3'b000, 0);
    add(0, 32'h0,        32'h0,   1, 1, 0, 1, 32'h0,        32'h0,   3'b000, 0);
    add(0, 32'h0,        32'h0,   1, 0, 0, 1, 32'h0,        32'h0,   3'b000, 0);

    #12;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready",  32'(in_ready),  32'h1);
    chk("rst_out_instr", out_instr,      32'h0);
    chk("rst_out_pc",    out_pc,         32'h0);
    chk("rst_raw_src",   32'(raw_src),   32'h0);
    chk("rst_imm_src",   32'(imm_src),   32'h7);
    chk("rst_illegal",   32'(illegal),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      drive(v.iv, v.instr, v.pc, v.ordy, v.fl);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(v.e_ov));
      chk($sformatf("v%0d_in_ready", i),  32'(in_ready),  32'(v.e_ir));
      chk($sformatf("v%0d_illegal", i),   32'(illegal),   32'(v.e_ill));
      if (v.e_ov) begin
        tmp = v.e_instr;
        chk($sformatf("v%0d_out_instr", i), out_instr,    v.e_instr);
        chk($sformatf("v%0d_out_pc", i),    out_pc,       v.e_pc);
        chk($sformatf("v%0d_raw_src", i),   32'(raw_src), 32'(tmp[31:7]));
        chk($sformatf("v%0d_imm_src", i),   32'(imm_src), 32'(v.e_imm));
      end
      @(negedge clk);
    end

    // async reset mid-stall: fill both entries, then drop rst_n between edges
    drive(1, 32'h00A00113, 32'h600, 0, 0);
    @(posedge clk); @(negedge clk);
    drive(1, 32'h00202223, 32'h604, 0, 0);
    @(posedge clk); #1;
    chk("fill_out_valid", 32'(out_valid), 32'h1);
    chk("fill_in_ready",  32'(in_ready),  32'h0);
    @(negedge clk);
    drive(0, 32'h0, 32'h0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'h0);
    chk("arst_in_ready",  32'(in_ready),  32'h1);
    chk("arst_illegal",   32'(illegal),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 32'h123452B7, 32'h700, 1, 0);
    @(posedge clk); #1;
    chk("post_rst_out_valid", 32'(out_valid), 32'h1);
    chk("post_rst_out_instr", out_instr,      32'h123452B7);
    chk("post_rst_imm_src",   32'(imm_src),   32'h4);
    @(negedge clk);
    drive(0, 32'h0, 32'h0, 1, 0);
    @(posedge clk); #1;
    chk("post_rst_drain", 32'(out_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_pipe.md
# if_id_pipe

IF/ID pipeline register for the core: accepts fetched instructions from the fetch stage over a valid/ready handshake and holds them in a 2-entry skid buffer. It presents the head instruction to decode, predecoding the immediate format (`imm_src`) and the immediate field slice (`raw_src`) that drive the sign extender directly. Supports stall via backpressure and a synchronous flush for branch/jump redirects.

## Interface
- `PC_W`, default 32: width of the program counter carried alongside each instruction.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: fetch stage presents an instruction.
- `in_ready` output 1: block can accept; registered, with no combinational dependence on `out_ready`.
- `in_instr` input 32: fetched instruction word.
- `in_pc` input PC_W: PC of `in_instr`.
- `flush` input 1: synchronous redirect; discards all held and incoming instructions.
- `out_valid` output 1: head entry valid.
- `out_ready` input 1: decode consumes the head this cycle.
- `out_instr` output 32: head instruction.
- `out_pc` output PC_W: head PC.
- `raw_src` output 25: `out_instr[31:7]`.
- `imm_src` output 3: predecoded immediate format of the head.
- `illegal` output 1: head is valid and its opcode is unrecognized.

## Operation
- Storage: main register (head) plus skid register, each with a valid bit. FIFO order is strict.
- Accept = `in_valid & in_ready & ~flush`. Pop = `out_valid & out_ready`.
- Accept with main empty, or with main full and popping while skid is empty: the entry is written into main.
- Accept with main full and not popping: the entry is written into skid.
- Pop with skid full: skid moves into main and skid is cleared. Accept cannot coincide with this, because `in_ready` is 0.
- Pop with skid empty and no accept: main is cleared.
- `in_ready` is the registered value of `~skid_valid`.
- Flush clears main and skid valid bits on the next edge. Flush overrides any accept or pop in the same cycle, and the incoming instruction is dropped.
- `out_valid` is the main valid bit. `out_instr`/`out_pc` come from the main data register.
- `imm_src` decode on `out_instr[6:0]`:
  - 0000011, 0010011, 1100111, 1110011 → 3'b000 (I)
  - 0100011 → 3'b001 (S)
  - 1100011 → 3'b010 (B)
  - 1101111 → 3'b011 (J)
  - 0110111, 0010111 → 3'b100 (U)
  - 0110011 (R) → 3'b111, not illegal
  - anything else → 3'b111 with `illegal = out_valid`
- Data registers need not be cleared on flush; only valid bits are cleared.

## Timing
- Reset values:
  - `out_valid` = 0, `in_ready` = 1.
  - `out_instr` = 0, `out_pc` = 0, `raw_src` = 0.
  - `imm_src` = 3'b111, `illegal` = 0.
  - Skid valid = 0.
- Latency: accept at edge N gives `out_valid` = 1 after edge N (visible in cycle N+1).
- Throughput: one instruction per cycle when `out_ready` is held at 1; skid stays empty.
- Backpressure: with main full and `out_ready` = 0, the next accept fills skid. `in_ready` falls after that edge. At most 2 entries are ever held.
- Release: the first pop with skid full moves skid into main. `in_ready` returns to 1 after that edge.
- `flush` asserted in cycle N: `out_valid` = 0 and `in_ready` = 1 from cycle N+1. An instruction presented in cycle N is never output.
- Flush in the same cycle as a pop: the pop completes on the decode side, and the remaining state is cleared.
- Reset asserted mid-operation: all valid bits clear immediately (asynchronously), with no clock required. After `rst_n` rises, the first accept is on the next edge.
- Outputs `out_*`, `raw_src`, `imm_src` and `illegal` are stable while `out_valid` = 1 and `out_ready` = 0.

## Test plan
- Reset then stream: reset, then `in_instr` = 0x00500093 (addi), 0x00112023 (sw), 0xFE000EE3 (beq), 0x008000EF (jal), 0x123452B7 (lui), with `out_ready` = 1. Required: each appears one cycle later with `imm_src` = 000, 001, 010, 011, 100 respectively. `raw_src` = `in_instr[31:7]` and `illegal` = 0 throughout.
- Backpressure: hold `out_ready` = 0 and offer 3 instructions. Required: 2 accepted, `in_ready` = 0 after the second. Then raise `out_ready`. Required: output order is preserved and `in_ready` returns to 1 one cycle after the first pop.
- Flush while full: with both entries held, assert `flush` while offering 0x00000013. Required: `out_valid` = 0 next cycle, `in_ready` = 1, and 0x00000013 is never output.
- Simultaneous accept+pop with main full and skid empty: the new word replaces the head. Required: no bubble and no duplicate.
- Illegal opcode: `in_instr` = 0x0000007F. Required: `illegal` = 1 and `imm_src` = 111. R-type 0x002081B3. Required: `illegal` = 0 and `imm_src` = 111.
- Async reset mid-stall: with 2 entries held, drop `rst_n` between edges. Required: `out_valid` = 0 and `in_ready` = 1 immediately, with no clock edge.
